// File: rtl/cook_timer.sv
// -----------------------------------------------------------------------------
// cook_timer
// Keypad-driven BCD MM:SS countdown controller. It sits directly ahead of the
// magnetron set/reset latch and emits one-cycle set/reset pulses on the edges
// where the magnetron should switch on or off.
//
// Optional feature macro: QUICK_START_EN
//   When defined, start in IDLE (time 0, door closed) loads 00:30 and begins
//   cooking on the same edge. When undefined, start in IDLE is ignored.
//
// Parameters:
//   TICK_DIV     clk cycles per one-second countdown tick (>= 2)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   digit        keypad BCD value
//   digit_valid  one-cycle strobe qualifying digit
//   start        start/resume request (level)
//   stop_clear   stop/clear request (level), beats start everywhere
//   door_closed  1 = door shut (already synchronised)
//   set          one-cycle pulse to latch set input
//   reset        one-cycle pulse to latch reset input
//   time_bcd     {min_tens, min_ones, sec_tens, sec_ones}
//   state        IDLE=0, SET_TIME=1, COOKING=2, PAUSED=3, DONE=4
//   done         high while state is DONE
// -----------------------------------------------------------------------------
module cook_timer #(
    parameter int TICK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  digit,
    input  logic        digit_valid,
    input  logic        start,
    input  logic        stop_clear,
    input  logic        door_closed,
    output logic        set,
    output logic        reset,
    output logic [15:0] time_bcd,
    output logic [2:0]  state,
    output logic        done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_TIME = 3'd1,
        ST_COOKING  = 3'd2,
        ST_PAUSED   = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t         state_r, nxt_state_s;
    logic [15:0]    time_r, nxt_time_s;
    logic [PW-1:0]  presc_r, nxt_presc_s;
    logic           set_r, reset_r, done_r;
    logic           nxt_set_s, nxt_reset_s, nxt_done_s;
    logic           digit_ok_s, tick_s;
    logic [15:0]    dec_time_s;

    // One-second BCD decrement with borrow chain; seconds are not normalised,
    // so a sec_tens of 9 simply counts down like any other digit.
    function automatic logic [15:0] dec_bcd(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        logic       borrow;
        mt = t[15:12];
        mo = t[11:8];
        st = t[7:4];
        so = t[3:0];
        if (so == 4'd0) begin
            so = 4'd9;
            borrow = 1'b1;
        end else begin
            so = so - 4'd1;
            borrow = 1'b0;
        end
        if (borrow) begin
            if (st == 4'd0) begin
                st = 4'd5;
                borrow = 1'b1;
            end else begin
                st = st - 4'd1;
                borrow = 1'b0;
            end
        end else begin
            borrow = 1'b0;
        end
        if (borrow) begin
            if (mo == 4'd0) begin
                mo = 4'd9;
                borrow = 1'b1;
            end else begin
                mo = mo - 4'd1;
                borrow = 1'b0;
            end
        end else begin
            borrow = 1'b0;
        end
        if (borrow) begin
            mt = mt - 4'd1;
        end else begin
            mt = mt;
        end
        return {mt, mo, st, so};
    endfunction

    assign digit_ok_s = digit_valid && (digit <= 4'd9);
    assign tick_s     = (presc_r == TICK_LAST);
    assign dec_time_s = dec_bcd(time_r);

    // State, time, prescaler and registered output pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            time_r  <= 16'h0000;
            presc_r <= {PW{1'b0}};
            set_r   <= 1'b0;
            reset_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= nxt_state_s;
            time_r  <= nxt_time_s;
            presc_r <= nxt_presc_s;
            set_r   <= nxt_set_s;
            reset_r <= nxt_reset_s;
            done_r  <= nxt_done_s;
        end
    end

    // Next-state, next-time and prescaler decisions.
    always_comb begin
        nxt_state_s = state_r;
        nxt_time_s  = time_r;
        nxt_presc_s = presc_r;
        case (state_r)
            ST_IDLE: begin
                if (stop_clear) begin
                    nxt_time_s = 16'h0000;
                end
`ifdef QUICK_START_EN
                else if (start && door_closed && (time_r == 16'h0000)) begin
                    nxt_time_s  = 16'h0030;
                    nxt_state_s = ST_COOKING;
                    nxt_presc_s = {PW{1'b0}};
                end
`endif
                else if (digit_ok_s) begin
                    nxt_time_s  = {time_r[11:0], digit};
                    nxt_state_s = ST_SET_TIME;
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_SET_TIME: begin
                if (stop_clear) begin
                    nxt_state_s = ST_IDLE;
                    nxt_time_s  = 16'h0000;
                end else if (start && door_closed && (time_r != 16'h0000)) begin
                    nxt_state_s = ST_COOKING;
                    nxt_presc_s = {PW{1'b0}};
                end else if (digit_ok_s) begin
                    nxt_time_s = {time_r[11:0], digit};
                end else begin
                    nxt_state_s = ST_SET_TIME;
                end
            end
            ST_COOKING: begin
                // Door/stop win over a coincident tick; the prescaler is held.
                if (!door_closed || stop_clear) begin
                    nxt_state_s = ST_PAUSED;
                end else if (tick_s) begin
                    nxt_presc_s = {PW{1'b0}};
                    nxt_time_s  = dec_time_s;
                    if (dec_time_s == 16'h0000) begin
                        nxt_state_s = ST_DONE;
                    end else begin
                        nxt_state_s = ST_COOKING;
                    end
                end else begin
                    nxt_presc_s = presc_r + {{(PW-1){1'b0}}, 1'b1};
                end
            end
            ST_PAUSED: begin
                if (stop_clear) begin
                    nxt_state_s = ST_IDLE;
                    nxt_time_s  = 16'h0000;
                end else if (start && door_closed) begin
                    nxt_state_s = ST_COOKING;
                end else begin
                    nxt_state_s = ST_PAUSED;
                end
            end
            ST_DONE: begin
                if (stop_clear || !door_closed) begin
                    nxt_state_s = ST_IDLE;
                    nxt_time_s  = 16'h0000;
                end else begin
                    nxt_state_s = ST_DONE;
                end
            end
            default: begin
                nxt_state_s = ST_IDLE;
                nxt_time_s  = 16'h0000;
                nxt_presc_s = {PW{1'b0}};
            end
        endcase
    end

    // Pulses follow magnetron intent: set on entering COOKING, reset on leaving.
    always_comb begin
        nxt_set_s   = (nxt_state_s == ST_COOKING) && (state_r != ST_COOKING);
        nxt_reset_s = (state_r == ST_COOKING) && (nxt_state_s != ST_COOKING);
        nxt_done_s  = (nxt_state_s == ST_DONE);
    end

    assign set      = set_r;
    assign reset    = reset_r;
    assign done     = done_r;
    assign time_bcd = time_r;
    assign state    = state_r;

endmodule

// File: tb/tb_cook_timer.sv
// -----------------------------------------------------------------------------
// tb_cook_timer
// Self-checking bench for cook_timer with TICK_DIV=4. A behavioural model keeps
// the remaining time as decimal minute and second fields and advances once per
// clock edge from the same inputs the DUT sees.
// -----------------------------------------------------------------------------
module tb_cook_timer;

    localparam int TD = 4;

    logic        clk;
    logic        rst;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        start;
    logic        stop_clear;
    logic        door_closed;
    logic        set;
    logic        reset;
    logic [15:0] time_bcd;
    logic [2:0]  state;
    logic        done;

    int n_checks;
    int n_err;

    // model state
    int m_state, m_m, m_s, m_presc;
    bit m_set, m_reset, m_done;

    cook_timer #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .digit(digit), .digit_valid(digit_valid),
        .start(start), .stop_clear(stop_clear), .door_closed(door_closed),
        .set(set), .reset(reset), .time_bcd(time_bcd), .state(state), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_m = 0; m_s = 0; m_presc = 0;
        m_set = 1'b0; m_reset = 1'b1; m_done = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] d, input logic dv, input logic st,
                              input logic sc, input logic dc);
        int prev;
        prev = m_state;
        case (m_state)
            0: begin
                if (sc) begin
                    m_m = 0; m_s = 0;
                end
`ifdef QUICK_START_EN
                else if (st && dc && m_m == 0 && m_s == 0) begin
                    m_s = 30; m_state = 2; m_presc = 0;
                end
`endif
                else if (dv && d <= 9) begin
                    m_m = (m_m % 10) * 10 + m_s / 10;
                    m_s = (m_s % 10) * 10 + int'(d);
                    m_state = 1;
                end
            end
            1: begin
                if (sc) begin
                    m_state = 0; m_m = 0; m_s = 0;
                end else if (st && dc && (m_m != 0 || m_s != 0)) begin
                    m_state = 2; m_presc = 0;
                end else if (dv && d <= 9) begin
                    m_m = (m_m % 10) * 10 + m_s / 10;
                    m_s = (m_s % 10) * 10 + int'(d);
                end
            end
            2: begin
                if (!dc || sc) begin
                    m_state = 3;
                end else if (m_presc == TD - 1) begin
                    m_presc = 0;
                    if (m_s > 0) m_s = m_s - 1;
                    else begin m_s = 59; m_m = m_m - 1; end
                    if (m_m == 0 && m_s == 0) m_state = 4;
                end else begin
                    m_presc = m_presc + 1;
                end
            end
            3: begin
                if (sc) begin
                    m_state = 0; m_m = 0; m_s = 0;
                end else if (st && dc) begin
                    m_state = 2;
                end
            end
            4: begin
                if (sc || !dc) begin
                    m_state = 0; m_m = 0; m_s = 0;
                end
            end
            default: m_state = 0;
        endcase
        m_set   = (m_state == 2) && (prev != 2);
        m_reset = (prev == 2) && (m_state != 2);
        m_done  = (m_state == 4);
    endtask

    function automatic logic [21:0] exp_vec();
        return {m_set, m_reset, m_done, 3'(m_state),
                4'(m_m / 10), 4'(m_m % 10), 4'(m_s / 10), 4'(m_s % 10)};
    endfunction

    // Drive one cycle of inputs, advance the model on the edge, settle.
    task automatic cyc(input logic [3:0] d, input logic dv, input logic st,
                       input logic sc, input logic dc);
        digit = d; digit_valid = dv; start = st; stop_clear = sc; door_closed = dc;
        @(posedge clk);
        model_step(d, dv, st, sc, dc);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        cyc(d, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle_cyc(input int n);
        for (int i = 0; i < n; i++) cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({set, reset, done, state, time_bcd} !== {1'b0, 1'b1, 1'b0, 3'd0, 16'h0000}) begin
            n_err++;
            $display("FAIL por_values got=%h want=%h", {set, reset, done, state, time_bcd},
                     {1'b0, 1'b1, 1'b0, 3'd0, 16'h0000});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cyc(1);
        n_checks++;
        if (reset !== 1'b0) begin
            n_err++; $display("FAIL reset_release got=%b want=0", reset);
        end
        key(4'd0); key(4'd7);
        cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_cyc(2);
        n_checks++;
        if (state !== 3'd2 || time_bcd !== 16'h0007) begin
            n_err++; $display("FAIL cook_0007 got=%0d/%h want=2/0007", state, time_bcd);
        end
        #2; rst = 1'b1; #1;
        model_reset();
        n_checks++;
        if ({set, reset, state, time_bcd} !== {1'b0, 1'b1, 3'd0, 16'h0000}) begin
            n_err++;
            $display("FAIL async_reset got=%h want=%h", {set, reset, state, time_bcd},
                     {1'b0, 1'b1, 3'd0, 16'h0000});
        end
        #2; rst = 1'b0;
        idle_cyc(1);
        n_checks++;
        if (reset !== 1'b0 || state !== 3'd0) begin
            n_err++; $display("FAIL async_release got=%b/%0d want=0/0", reset, state);
        end
    endtask

    task automatic test_digits();
        key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
        n_checks++;
        if (time_bcd !== 16'h2345 || state !== 3'd1) begin
            n_err++; $display("FAIL digit_shift got=%h/%0d want=2345/1", time_bcd, state);
        end
        key(4'hA);
        n_checks++;
        if (time_bcd !== 16'h2345 || state !== 3'd1) begin
            n_err++; $display("FAIL digit_invalid got=%h/%0d want=2345/1", time_bcd, state);
        end
        cyc(4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (state !== 3'd0 || time_bcd !== 16'h0000 || set !== 1'b0 || reset !== 1'b0) begin
            n_err++; $display("FAIL set_time_clear got=%0d/%h want=0/0000", state, time_bcd);
        end
    endtask

    task automatic test_first_tick();
        key(4'd1); key(4'd0); key(4'd0);
        cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (set !== 1'b1 || reset !== 1'b0 || state !== 3'd2) begin
            n_err++; $display("FAIL start_set got=%b%b/%0d want=10/2", set, reset, state);
        end
        idle_cyc(1);
        n_checks++;
        if (set !== 1'b0) begin
            n_err++; $display("FAIL set_one_cycle got=%b want=0", set);
        end
        idle_cyc(2);
        n_checks++;
        if (time_bcd !== 16'h0100) begin
            n_err++; $display("FAIL pre_tick got=%h want=0100", time_bcd);
        end
        idle_cyc(1);
        n_checks++;
        if (time_bcd !== 16'h0059) begin
            n_err++; $display("FAIL first_tick got=%h want=0059", time_bcd);
        end
        cyc(4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (state !== 3'd0) begin
            n_err++; $display("FAIL stop_twice got=%0d want=0", state);
        end
    endtask

    task automatic test_done();
        logic [15:0] want;
        key(4'd0); key(4'd3);
        cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            idle_cyc(TD);
            want = 16'(3 - k);
            n_checks++;
            if (time_bcd !== want) begin
                n_err++; $display("FAIL countdown_%0d got=%h want=%h", k, time_bcd, want);
            end
        end
        n_checks++;
        if ({state, reset, set, done} !== {3'd4, 1'b1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL done_edge got=%0d/%b%b%b want=4/101", state, reset, set, done);
        end
        idle_cyc(1);
        n_checks++;
        if (reset !== 1'b0 || done !== 1'b1 || state !== 3'd4) begin
            n_err++; $display("FAIL done_hold got=%b%b/%0d want=01/4", reset, done, state);
        end
        cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (state !== 3'd4 || set !== 1'b0) begin
            n_err++; $display("FAIL done_start_ignored got=%0d/%b want=4/0", state, set);
        end
        cyc(4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (state !== 3'd0 || done !== 1'b0 || reset !== 1'b0) begin
            n_err++; $display("FAIL done_clear got=%0d/%b want=0/0", state, done);
        end
    endtask

    task automatic test_pause();
        key(4'd2); key(4'd0);
        cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle_cyc(2);
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({state, reset, set, time_bcd} !== {3'd3, 1'b1, 1'b0, 16'h0020}) begin
            n_err++; $display("FAIL door_pause got=%0d/%b%b/%h want=3/10/0020",
                              state, reset, set, time_bcd);
        end
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if ({state, set, reset} !== {3'd2, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL resume got=%0d/%b%b want=2/10", state, set, reset);
        end
        for (int i = 0; i < 4; i++) begin
            idle_cyc(1);
            n_checks++;
            if ({set, reset, done, state, time_bcd} !== exp_vec()) begin
                n_err++; $display("FAIL resume_run_%0d got=%h want=%h", i,
                                  {set, reset, done, state, time_bcd}, exp_vec());
            end
        end
        n_checks++;
        if (time_bcd !== 16'h0019) begin
            n_err++; $display("FAIL resume_tick got=%h want=0019", time_bcd);
        end
        cyc(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(4'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (state !== 3'd0 || time_bcd !== 16'h0000 || set !== 1'b0) begin
            n_err++; $display("FAIL stop_beats_start got=%0d/%h/%b want=0/0000/0",
                              state, time_bcd, set);
        end
    endtask

    task automatic test_quick_start();
        cyc(4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
`ifdef QUICK_START_EN
        if ({state, set, time_bcd} !== {3'd2, 1'b1, 16'h0030}) begin
            n_err++; $display("FAIL quick_start got=%0d/%b/%h want=2/1/0030", state, set, time_bcd);
        end
`else
        if ({state, set, time_bcd} !== {3'd0, 1'b0, 16'h0000}) begin
            n_err++; $display("FAIL quick_start got=%0d/%b/%h want=0/0/0000", state, set, time_bcd);
        end
`endif
        cyc(4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        cyc(4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        logic [3:0] d;
        logic dv, st, sc, dc;
        for (int i = 0; i < 3000; i++) begin
            d  = 4'($urandom_range(0, 15));
            dv = ($urandom_range(0, 99) < 35);
            st = ($urandom_range(0, 99) < 20);
            sc = ($urandom_range(0, 99) < 3);
            dc = ($urandom_range(0, 99) < 92);
            cyc(d, dv, st, sc, dc);
            n_checks++;
            if ({set, reset, done, state, time_bcd} !== exp_vec() || (set && reset)) begin
                n_err++; $display("FAIL random_%0d got=%h want=%h", i,
                                  {set, reset, done, state, time_bcd}, exp_vec());
            end
        end
    endtask

    initial begin
        n_checks = 0; n_err = 0;
        rst = 1'b1; digit = 4'd0; digit_valid = 1'b0; start = 1'b0;
        stop_clear = 1'b0; door_closed = 1'b1;
        model_reset();
        test_reset();
        test_digits();
        test_first_tick();
        test_done();
        test_pause();
        test_quick_start();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
Control stage directly upstream of the magnetron set/reset latch in the nivel3 microwave design. Accepts keypad digits, start, stop/clear and the door switch, and runs a BCD MM:SS countdown. Emits one-cycle set/reset pulses that drive the latch's set and reset inputs. Exposes the remaining time for the display stage.

Parameters:
TICK_DIV, 50000000, clk cycles per one-second countdown tick (>=2; benches use 4)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
digit  input  4  keypad value, BCD
digit_valid  input  1  one-cycle strobe qualifying digit
start  input  1  start/resume request, level sampled each clk
stop_clear  input  1  stop/clear request, level sampled each clk
door_closed  input  1  1 = door shut (already synchronised)
set  output  1  one-cycle pulse to latch set input
reset  output  1  one-cycle pulse to latch reset input
time_bcd  output  16  {min_tens, min_ones, sec_tens, sec_ones}
state  output  3  IDLE=0, SET_TIME=1, COOKING=2, PAUSED=3, DONE=4
done  output  1  high while state==DONE

Behaviour:
- Reset (async, while rst=1): state=IDLE, time_bcd=0, prescaler=0, set=0, reset=1, done=0. First clk after release: reset=0.
- All outputs are registered. set/reset change on the same edge as state. set and reset are never both 1.
- Digit entry, in IDLE or SET_TIME only:
  - digit_valid with digit<=9 -> time_bcd <= {time_bcd[11:0], digit}; top digit dropped; state -> SET_TIME.
  - digit>9 is ignored.
  - In any other state, digit entry is ignored.
- Seconds are not normalised on entry: 00:90 counts 90, 89, ...
- SET_TIME:
  - stop_clear -> IDLE, time=0.
  - Else start & door_closed & time!=0 -> COOKING, set=1 for one cycle, prescaler cleared.
  - start with door open or time==0 -> no effect.
- COOKING, priority highest first:
  1. door_closed=0 -> PAUSED, reset pulse.
  2. stop_clear -> PAUSED, reset pulse.
  3. Tick -> decrement.
  - A tick coinciding with 1 or 2 is discarded.
- Prescaler:
  - Counts only in COOKING; tick when prescaler==TICK_DIV-1, then wraps to 0.
  - First decrement occurs TICK_DIV cycles after COOKING entry.
  - Held (not cleared) in PAUSED.
- Decrement (BCD borrow chain):
  - sec_ones 0 -> 9 with borrow; sec_tens 0 -> 5 with borrow; min_ones 0 -> 9 with borrow; min_tens decrements.
- Tick that makes time reach 0000 -> DONE on that edge, reset pulse, done=1.
- PAUSED:
  - stop_clear -> IDLE, time=0.
  - Else start & door_closed -> COOKING, set pulse, prescaler resumes from its held value.
  - time_bcd frozen.
- DONE: stop_clear or door_closed=0 -> IDLE, time=0, done=0. start is ignored.
- stop_clear beats start in every state.
- No pulse is generated on a transition that does not change magnetron intent (e.g. SET_TIME->IDLE).

Optional Feature:
- Macro QUICK_START_EN.
- Defined: start in IDLE with time==0 and door_closed loads time_bcd=0030 and enters COOKING with a set pulse, all on one edge.
- Undefined: start in IDLE has no effect.

Test Plan:
- COOKING with 00:07, assert rst asynchronously between edges -> immediately state=0, time_bcd=16'h0000, set=0, reset=1; reset=0 one clk after release.
- Digits 1,2,3,4,5 then digit 4'hA -> time_bcd=16'h2345, state=1; the 0xA strobe changes nothing.
- TICK_DIV=4: enter 1,0,0 (01:00), door closed, start -> set=1 for exactly one cycle; time_bcd=16'h0059 four cycles later.
- TICK_DIV=4: enter 0,3, start -> time_bcd 0003 -> 0002 -> 0001 -> 0000 at 4-cycle intervals; on the 0000 edge state=4, reset=1 for one cycle, done=1; stop_clear -> state=0, done=0.
- COOKING at 00:20, drop door_closed -> state=3, reset pulse, time holds 0020. Raise door, start -> set pulse, countdown continues. Same-cycle start & stop_clear in PAUSED -> state=0, time_bcd=0.
- QUICK_START_EN defined: in IDLE, time 0, door closed, start -> time_bcd=16'h0030, state=2, set pulse. Undefined: state stays 0, no pulse.
